// File: rtl/sw_debounce8_if.sv
// sw_debounce8_if -- switch-side and encoder-side signals of the debouncer.
//   sw_in[7:0], en_in : raw asynchronous switch levels (en_in is channel 8)
//   sw_out[7:0]       : debounced switches, feeds encoder I[7:0]
//   ei_out            : debounced enable, feeds encoder EI
//   chg               : one-cycle pulse after any output bit toggled
//   busy              : some channel is mid-count
// master drives the raw switches, slave is the debouncer.
interface sw_debounce8_if;
  logic [7:0] sw_in;
  logic       en_in;
  logic [7:0] sw_out;
  logic       ei_out;
  logic       chg;
  logic       busy;

  modport master (output sw_in, en_in, input sw_out, ei_out, chg, busy);
  modport slave  (input sw_in, en_in, output sw_out, ei_out, chg, busy);
endinterface

// File: rtl/sw_debounce8.sv
// sw_debounce8 -- nine-channel switch synchroniser and debouncer feeding the
// 8-to-3 priority encoder of the hex display path.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sw_debounce8_if.slave (raw switches in, clean vector/strobes out)
// Build option: define SW_DEBOUNCE_FILTER_EN to include the per-channel
// hold-time filter (STABLE/COUNT FSM + counter). Without it each output is
// its synchronised input registered once more and busy is tied low.
// Parameters DEBOUNCE_CYCLES (1 .. 2**CNT_W-1) and CNT_W only matter when
// the filter is built in.

// One channel: two-flop synchroniser plus optional hold-time filter.
module sw_debounce8_chan #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic out_o,
  output logic toggle_o,  // out_o flips on the coming edge
  output logic busy_o
);
  logic s1_q, s2_q, out_q;

`ifdef SW_DEBOUNCE_FILTER_EN
  typedef enum logic {ST_STABLE, ST_COUNT} state_e;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           st_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      out_q <= 1'b0;
      st_q  <= ST_STABLE;
      cnt_q <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      case (st_q)
        ST_STABLE:
          if (s2_q != out_q) begin
            // a one-cycle hold needs no counting state at all
            if (DEBOUNCE_CYCLES == 1) out_q <= s2_q;
            else begin
              cnt_q <= CNT_W'(1);
              st_q  <= ST_COUNT;
            end
          end
        ST_COUNT:
          if (s2_q == out_q) begin
            // bounced back before the hold time: discard the attempt
            cnt_q <= '0;
            st_q  <= ST_STABLE;
          end else if (cnt_q == LAST) begin
            out_q <= s2_q;
            cnt_q <= '0;
            st_q  <= ST_STABLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        default: begin
          cnt_q <= '0;
          st_q  <= ST_STABLE;
        end
      endcase
    end
  end

  always_comb begin
    toggle_o = 1'b0;
    if (s2_q != out_q)
      toggle_o = (st_q == ST_STABLE) ? (DEBOUNCE_CYCLES == 1)
                                     : (cnt_q == LAST);
  end
  assign busy_o = (cnt_q != '0);
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      out_q <= 1'b0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      out_q <= s2_q;
    end
  end

  assign toggle_o = (s2_q != out_q);
  assign busy_o   = 1'b0;
`endif

  assign out_o = out_q;
endmodule

module sw_debounce8 #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic          clk,
  input  logic          rst,
  sw_debounce8_if.slave bus
);
  localparam int NUM_CH = 9;

  logic [NUM_CH-1:0] raw, clean, tgl, bsy;
  logic              chg_q;

  assign raw = {bus.en_in, bus.sw_in};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sw_debounce8_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (raw[i]),
      .out_o    (clean[i]),
      .toggle_o (tgl[i]),
      .busy_o   (bsy[i])
    );
  end

  // one pulse per toggling edge, however many channels moved together
  always_ff @(posedge clk) begin
    if (rst) chg_q <= 1'b0;
    else     chg_q <= |tgl;
  end

  assign bus.sw_out = clean[7:0];
  assign bus.ei_out = clean[8];
  assign bus.chg    = chg_q;
  assign bus.busy   = |bsy;
endmodule

// File: tb/tb_sw_debounce8.sv
// Bench for sw_debounce8 with DEBOUNCE_CYCLES=4. A history-based reference
// model (raw samples per edge, reset per edge) predicts every output; each
// scenario task also checks the directed expectations for its case.
module tb_sw_debounce8;
  localparam int D  = 4;
  localparam int HN = 4096;
`ifdef SW_DEBOUNCE_FILTER_EN
  localparam int LAT  = D + 1;  // edges after the capturing edge
  localparam bit FILT = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sw_debounce8_if bus ();

  sw_debounce8 #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state: history indexed by edge number
  logic [8:0] raw_h [0:HN-1];
  bit         rst_h [0:HN-1];
  logic [8:0] out_h [0:HN-1];
  int         n = 0;
  logic [8:0] exp_out;
  logic       exp_chg, exp_busy;

  // level the filter sees at edge k: the raw sample taken two edges earlier,
  // or 0 if a reset cleared the synchroniser in between
  function automatic logic [8:0] seen(int k);
    if (k < 2) return '0;
    if (rst_h[k-1] || rst_h[k-2]) return '0;
    return raw_h[k-2];
  endfunction

  task automatic model_step();
    logic [8:0] prev, cur, sv;
    bit busy;
    int run;
    if (n >= HN) begin
      $display("FAIL history_overflow edges=%0d limit=%0d", n, HN);
      $fatal(1);
    end
    raw_h[n] = {bus.en_in, bus.sw_in};
    rst_h[n] = rst;
    prev = (n == 0) ? 9'h0 : out_h[n-1];
    cur  = prev;
    busy = 1'b0;
    if (rst) cur = '0;
    else if (FILT) begin
      for (int c = 0; c < 9; c++) begin
        // length of the current run of samples disagreeing with the output
        run = 0;
        for (int k = n; k > n - D; k--) begin
          if (k < 2 || rst_h[k]) break;
          sv = seen(k);
          if (sv[c] == out_h[k-1][c]) break;
          run++;
          if (out_h[k-1][c] != out_h[k-2][c]) break;
        end
        if (run == D) cur[c] = ~prev[c];
        else if (run > 0) busy = 1'b1;
      end
    end else begin
      cur = seen(n);
    end
    out_h[n] = cur;
    exp_out  = cur;
    exp_chg  = !rst && (cur != prev);
    exp_busy = busy;
    n++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.sw_in = 8'hFF; bus.en_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if ({bus.ei_out, bus.sw_out, bus.chg, bus.busy} !== 11'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got ei=%b sw=%h chg=%b busy=%b want all 0",
                 i, bus.ei_out, bus.sw_out, bus.chg, bus.busy);
      end
      checks++;
    end
    bus.sw_in = 8'h00; bus.en_in = 1'b0; rst = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      cyc();
      if ({bus.ei_out, bus.sw_out, bus.chg, bus.busy} !== {exp_out, exp_chg, exp_busy}) begin
        errors++;
        $display("FAIL reset_release edge=%0d got %h/%b/%b want %h/%b/%b", n,
                 {bus.ei_out, bus.sw_out}, bus.chg, bus.busy, exp_out, exp_chg, exp_busy);
      end
      checks++;
    end
  endtask

  task automatic test_clean_step();
    bus.sw_in = 8'h80; bus.en_in = 1'b1;
    for (int i = 0; i < LAT + 3; i++) begin
      cyc();
      if ({bus.ei_out, bus.sw_out, bus.chg, bus.busy} !==
          {(i >= LAT) ? 9'h180 : 9'h000, i == LAT, FILT && i >= 2 && i < LAT}) begin
        errors++;
        $display("FAIL clean_step i=%0d got %h/%b/%b want out=%h chg=%b busy=%b", i,
                 {bus.ei_out, bus.sw_out}, bus.chg, bus.busy,
                 (i >= LAT) ? 9'h180 : 9'h000, i == LAT, FILT && i >= 2 && i < LAT);
      end
      checks++;
    end
    bus.sw_in = 8'h00; bus.en_in = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      cyc();
      if ({bus.ei_out, bus.sw_out, bus.chg, bus.busy} !== {exp_out, exp_chg, exp_busy}) begin
        errors++;
        $display("FAIL clean_fall edge=%0d got %h/%b/%b want %h/%b/%b", n,
                 {bus.ei_out, bus.sw_out}, bus.chg, bus.busy, exp_out, exp_chg, exp_busy);
      end
      checks++;
    end
  endtask

  task automatic test_bounce();
    logic [4:0] pat = 5'b10101;
    int pulses = 0, rise = -1;
    for (int i = 0; i < 16; i++) begin
      bus.sw_in = (i < 5) ? {4'h0, pat[i], 3'b000} : 8'h08;
      cyc();
      if (bus.chg) pulses++;
      if (rise < 0 && bus.sw_out[3]) rise = i;
      if ({bus.ei_out, bus.sw_out, bus.chg, bus.busy} !== {exp_out, exp_chg, exp_busy}) begin
        errors++;
        $display("FAIL bounce_model i=%0d got %h/%b/%b want %h/%b/%b", i,
                 {bus.ei_out, bus.sw_out}, bus.chg, bus.busy, exp_out, exp_chg, exp_busy);
      end
      checks++;
    end
    // filtered: one rise D stable samples after the last raw rise;
    // bypass: every raw edge passes through
    if (pulses !== (FILT ? 1 : 5) || (FILT && rise !== 4 + LAT)) begin
      errors++;
      $display("FAIL bounce_result got pulses=%0d rise=%0d want pulses=%0d rise=%0d",
               pulses, rise, FILT ? 1 : 5, FILT ? 4 + LAT : LAT);
    end
    checks++;
    bus.sw_in = 8'h00;
    for (int i = 0; i < LAT + 2; i++) cyc();
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      bus.sw_in = (i < 3) ? 8'h20 : 8'h00;
      cyc();
      if (bus.chg) pulses++;
      if ({bus.ei_out, bus.sw_out, bus.chg, bus.busy} !== {exp_out, exp_chg, exp_busy}) begin
        errors++;
        $display("FAIL glitch_model i=%0d got %h/%b/%b want %h/%b/%b", i,
                 {bus.ei_out, bus.sw_out}, bus.chg, bus.busy, exp_out, exp_chg, exp_busy);
      end
      checks++;
    end
    if (pulses !== (FILT ? 0 : 2) || bus.busy !== 1'b0 || bus.sw_out !== 8'h00) begin
      errors++;
      $display("FAIL glitch_result got pulses=%0d busy=%b sw=%h want pulses=%0d busy=0 sw=00",
               pulses, bus.busy, bus.sw_out, FILT ? 0 : 2);
    end
    checks++;
  endtask

  task automatic test_multi();
    int pulses = 0;
    bus.sw_in = 8'h0C;
    for (int i = 0; i < LAT + 4; i++) begin
      cyc();
      if (bus.chg) pulses++;
      if (bus.sw_out !== ((i >= LAT) ? 8'h0C : 8'h00)) begin
        errors++;
        $display("FAIL multi_step i=%0d got sw=%h want %h", i, bus.sw_out,
                 (i >= LAT) ? 8'h0C : 8'h00);
      end
      checks++;
    end
    if (pulses !== 1) begin
      errors++;
      $display("FAIL multi_chg got pulses=%0d want 1", pulses);
    end
    checks++;
    bus.sw_in = 8'h00;
    for (int i = 0; i < LAT + 3; i++) cyc();
  endtask

  task automatic test_reset_mid();
    bus.sw_in = 8'h01;
    for (int i = 0; i < 4; i++) cyc();  // counters at 2 in the filtered build
    rst = 1'b1;
    cyc();
    if ({bus.sw_out, bus.chg, bus.busy} !== 10'h0) begin
      errors++;
      $display("FAIL reset_mid got sw=%h chg=%b busy=%b want 00/0/0",
               bus.sw_out, bus.chg, bus.busy);
    end
    checks++;
    rst = 1'b0;
    for (int i = 1; i < LAT + 4; i++) begin
      cyc();
      if (bus.sw_out !== ((i >= LAT + 1) ? 8'h01 : 8'h00) || (!FILT && bus.busy !== 1'b0)) begin
        errors++;
        $display("FAIL reset_mid_release i=%0d got sw=%h busy=%b want sw=%h", i,
                 bus.sw_out, bus.busy, (i >= LAT + 1) ? 8'h01 : 8'h00);
      end
      checks++;
    end
    bus.sw_in = 8'h00;
    for (int i = 0; i < LAT + 3; i++) cyc();
  endtask

  task automatic test_random();
    logic [8:0] lv = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) lv[$urandom_range(8)] ^= 1'b1;
      bus.sw_in = lv[7:0]; bus.en_in = lv[8];
      rst = ($urandom_range(99) == 0);
      cyc();
      if ({bus.ei_out, bus.sw_out, bus.chg, bus.busy} !== {exp_out, exp_chg, exp_busy}) begin
        errors++;
        $display("FAIL random edge=%0d got %h/%b/%b want %h/%b/%b", n,
                 {bus.ei_out, bus.sw_out}, bus.chg, bus.busy, exp_out, exp_chg, exp_busy);
      end
      checks++;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus.sw_in = 8'h00; bus.en_in = 1'b0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_multi();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
